fifo_bram_ctrl: RTL and testbench
=================================

# fifo_bram_ctrl

Controller sequencing the single-port FIFO storage RAM (DEPTH entries, one access per cycle) into a synchronous FIFO. Owns write/read pointers, occupancy, full/empty, and per-cycle arbitration between push and pop requesters. Drives the RAM's chip-select, write-enable, output-enable and address buses, and returns popped data with a fixed two-cycle latency. Sits between the producer/consumer logic and the RAM instance.

## Interface
- DATA_WIDTH, 4, data word width
- ADDRESS_WIDTH, 4, RAM address width
- DEPTH, 11, number of RAM entries used; 2 ≤ DEPTH ≤ 2**ADDRESS_WIDTH
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_req  in  1  push request; wr_data valid while high
- wr_data  in  DATA_WIDTH  push data
- wr_ack  out  1  push granted this cycle (combinational)
- rd_req  in  1  pop request
- rd_ack  out  1  pop granted this cycle (combinational)
- rd_data  out  DATA_WIDTH  popped word, registered
- rd_valid  out  1  rd_data valid, one-cycle pulse
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  ADDRESS_WIDTH+1  occupancy
- ram_cs, ram_we, ram_oe  out  1 each  RAM strobes
- ram_addr_wr, ram_addr_rd  out  ADDRESS_WIDTH each  RAM addresses
- ram_din  out  DATA_WIDTH  RAM write data (= wr_data)
- ram_dout  in  DATA_WIDTH  RAM read data

## Operation
- Eligibility: push_ok = wr_req & !full; pop_ok = rd_req & !empty.
- Arbitration (one grant max per cycle): only one eligible → grant it. Both eligible → round-robin via prio bit: prio=0 grant write, prio=1 grant read; after a contested grant prio flips to favour the loser. Uncontested grants leave prio unchanged.
- Write grant: wr_ack=1, ram_cs=1, ram_we=1, ram_oe=0, ram_addr_wr=wr_ptr; at edge wr_ptr advances, count+1.
- Read grant: rd_ack=1, ram_cs=1, ram_we=0, ram_oe=1, ram_addr_wr=ram_addr_rd=rd_ptr (RAM sources read data via the write-address bus, so both buses carry rd_ptr); at edge rd_addr_hold<=rd_ptr, rd_ptr advances, count-1.
- No grant: ram_cs=ram_we=ram_oe=0, ram_addr_wr=wr_ptr, ram_addr_rd=rd_addr_hold.
- Pointers wrap DEPTH-1 → 0; never exceed DEPTH-1.
- Read pipeline: rd_pend<=rd_ack; when rd_pend, rd_data<=ram_dout and rd_valid<=1, else rd_valid<=0; rd_data holds otherwise.
- Requests not acked must be held by requester; no internal queuing.
- Push while full or pop while empty: no ack, no RAM strobe, no state change.

## Timing
- Reset (async assert, sync-safe deassert): wr_ptr=rd_ptr=rd_addr_hold=0, count=0, prio=0, rd_pend=0, rd_valid=0, rd_data=0; hence empty=1, full=0, all RAM strobes 0.
- Reset mid-operation drops any in-flight pop (rd_valid stays 0); RAM contents not cleared.
- Pop latency: rd_ack in cycle N → rd_valid=1 with data in cycle N+2. Back-to-back pops give one word per cycle.
- Push: data written at end of grant cycle; word poppable from next cycle (empty falls cycle N+1).
- full/empty/count update on the edge ending the grant cycle.
- Throughput: sum of pushes+pops ≤ 1 per cycle; contested steady state alternates W,R,W,R.

## Test plan
- Reset with rst_n=0 mid-pop → rd_valid=0, count=0, empty=1, ram_cs=0 immediately, no rd_valid after release.
- Push 0x1..0xB (11 words) with rd_req=0 → wr_ack every cycle, full=1 after 11th, 12th push gets wr_ack=0, ram_cs=0.
- From full, pop 11 → rd_data sequence 0x1..0xB, each 2 cycles after rd_ack, empty=1 after last; extra pop gets rd_ack=0.
- Wrap: push 8, pop 8, push 8, pop 8 → ram_addr_wr goes ...A,0,1..., data order preserved, count returns 0.
- Contention: count=5, wr_req=rd_req=1 for 6 cycles → grants W,R,W,R,W,R; count=5 at end; ram_we/ram_oe never both 1.
- Empty with simultaneous wr_req,rd_req → write granted only; next cycle read granted, returns pushed value.

Source files
------------

// File: rtl/fifo_bram_ctrl.sv
// fifo_bram_ctrl: sequences a single-port RAM into a synchronous FIFO with round-robin push/pop arbitration
module fifo_bram_ctrl #(
    parameter int DATA_WIDTH    = 4,
    parameter int ADDRESS_WIDTH = 4,
    parameter int DEPTH         = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_req,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     wr_ack,
    input  logic                     rd_req,
    output logic                     rd_ack,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic [ADDRESS_WIDTH:0]   count,
    output logic                     ram_cs,
    output logic                     ram_we,
    output logic                     ram_oe,
    output logic [ADDRESS_WIDTH-1:0] ram_addr_wr,
    output logic [ADDRESS_WIDTH-1:0] ram_addr_rd,
    output logic [DATA_WIDTH-1:0]    ram_din,
    input  logic [DATA_WIDTH-1:0]    ram_dout
);
    localparam logic [ADDRESS_WIDTH-1:0] LAST     = ADDRESS_WIDTH'(DEPTH - 1);
    localparam logic [ADDRESS_WIDTH:0]   FULL_CNT = (ADDRESS_WIDTH + 1)'(DEPTH);

    logic [ADDRESS_WIDTH-1:0] wr_ptr, rd_ptr, rd_addr_hold;
    logic prio, rd_pend, push_ok, pop_ok;

    always_comb begin
        full        = count == FULL_CNT;
        empty       = count == '0;
        push_ok     = wr_req & ~full;
        pop_ok      = rd_req & ~empty;
        wr_ack      = push_ok & (~pop_ok | ~prio);
        rd_ack      = pop_ok & (~push_ok | prio);
        ram_cs      = wr_ack | rd_ack;
        ram_we      = wr_ack;
        ram_oe      = rd_ack;
        // the RAM reads through the write-address bus, so a read drives rd_ptr on both
        ram_addr_wr = rd_ack ? rd_ptr : wr_ptr;
        ram_addr_rd = rd_ack ? rd_ptr : rd_addr_hold;
        ram_din     = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rd_addr_hold <= '0;
            count        <= '0;
            prio         <= 1'b0;
            rd_pend      <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
        end else begin
            if (wr_ack) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + ADDRESS_WIDTH'(1);
                count  <= count + (ADDRESS_WIDTH + 1)'(1);
            end
            if (rd_ack) begin
                rd_addr_hold <= rd_ptr;
                rd_ptr       <= (rd_ptr == LAST) ? '0 : rd_ptr + ADDRESS_WIDTH'(1);
                count        <= count - (ADDRESS_WIDTH + 1)'(1);
            end
            if (push_ok & pop_ok)
                prio <= ~prio;
            rd_pend  <= rd_ack;
            rd_valid <= rd_pend;
            if (rd_pend)
                rd_data <= ram_dout;
        end
    end
endmodule

// File: tb/tb_fifo_bram_ctrl.sv
// tb_fifo_bram_ctrl: directed scoreboard bench for fifo_bram_ctrl with a behavioural RAM
module tb_fifo_bram_ctrl;
    localparam int DW = 4;
    localparam int AW = 4;
    localparam int D  = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_req, rd_req;
    logic [DW-1:0] wr_data;
    logic          wr_ack, rd_ack, rd_valid, full, empty;
    logic [DW-1:0] rd_data, ram_din, ram_dout;
    logic [AW:0]   count;
    logic          ram_cs, ram_we, ram_oe;
    logic [AW-1:0] ram_addr_wr, ram_addr_rd;
    logic [DW-1:0] mem [2**AW];

    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } sb_t;

    sb_t           sb[$];
    logic [DW-1:0] fq[$];
    int            tests = 0, fails = 0, cyc = 0;
    int            mwp = 0, mrp = 0, mhold = 0;
    logic          mprio = 1'b0;

    always #5 clk = ~clk;

    fifo_bram_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .count(count),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_addr_wr(ram_addr_wr), .ram_addr_rd(ram_addr_rd),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // single-port RAM: registered read, addressed through the write-address bus
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr_wr] <= ram_din;
        if (ram_cs && ram_oe) ram_dout <= mem[ram_addr_wr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic w, input logic [DW-1:0] wd, input logic r);
        logic pw, pr, gw, gr;
        int   mc;
        @(negedge clk);
        wr_req  = w;
        wr_data = wd;
        rd_req  = r;
        #1;
        mc = fq.size();
        pw = w && mc < D;
        pr = r && mc > 0;
        gw = pw && (!pr || !mprio);
        gr = pr && (!pw || mprio);
        chk("wr_ack", wr_ack, gw);
        chk("rd_ack", rd_ack, gr);
        chk("ram_cs", ram_cs, gw | gr);
        chk("ram_we", ram_we, gw);
        chk("ram_oe", ram_oe, gr);
        chk("ram_addr_wr", ram_addr_wr, gr ? mrp : mwp);
        chk("ram_addr_rd", ram_addr_rd, gr ? mrp : mhold);
        chk("count", count, mc);
        chk("full", full, mc == D);
        chk("empty", empty, mc == 0);
        chk("rd_valid", rd_valid, sb.size() > 0 && sb[0].due == cyc);
        if (rd_valid && sb.size() > 0) begin
            chk("rd_data", rd_data, sb[0].d);
            void'(sb.pop_front());
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            void'(sb.pop_front());
        end
        if (gw) begin
            fq.push_back(wd);
            mwp = (mwp == D - 1) ? 0 : mwp + 1;
        end
        if (gr) begin
            sb.push_back('{fq.pop_front(), cyc + 2});
            mhold = mrp;
            mrp   = (mrp == D - 1) ? 0 : mrp + 1;
        end
        if (pw && pr) mprio = !mprio;
        cyc++;
    endtask

    task automatic model_reset();
        fq.delete();
        sb.delete();
        mwp   = 0;
        mrp   = 0;
        mhold = 0;
        mprio = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        wr_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_ram_cs", ram_cs, 1'b0);
        rst_n = 1'b1;

        // fill to full, then one rejected push
        for (int i = 1; i <= D; i++) step(1'b1, DW'(i), 1'b0);
        step(1'b1, 4'hC, 1'b0);
        chk("full_after_fill", full, 1'b1);

        // drain, with one rejected pop at the end
        repeat (D + 1) step(1'b0, '0, 1'b1);
        repeat (3) step(1'b0, '0, 1'b0);

        // pointer wrap
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) step(1'b1, DW'(i + 3 * k + 2), 1'b0);
            repeat (8) step(1'b0, '0, 1'b1);
            repeat (3) step(1'b0, '0, 1'b0);
        end
        chk("wrap_count", count, 0);

        // contention from count=5
        for (int i = 0; i < 5; i++) step(1'b1, DW'(i + 9), 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, DW'(i + 1), 1'b1);
            chk("no_we_oe_overlap", ram_we & ram_oe, 1'b0);
        end
        step(1'b0, '0, 1'b0);
        chk("contention_count", count, 5);
        repeat (6) step(1'b0, '0, 1'b1);
        repeat (3) step(1'b0, '0, 1'b0);

        // simultaneous requests while empty
        step(1'b1, 4'hD, 1'b1);
        step(1'b0, '0, 1'b1);
        repeat (3) step(1'b0, '0, 1'b0);

        // reset in the middle of a pop
        for (int i = 0; i < 3; i++) step(1'b1, 4'h7, 1'b0);
        step(1'b0, '0, 1'b1);
        @(negedge clk);
        rd_req = 1'b1;
        rst_n  = 1'b0;
        #1;
        chk("midrst_rd_valid", rd_valid, 1'b0);
        chk("midrst_count", count, 0);
        chk("midrst_empty", empty, 1'b1);
        chk("midrst_ram_cs", ram_cs, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(1'b0, '0, 1'b0);
        chk("post_rst_rd_data", rd_data, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
